// File: rtl/phys_reg_free_list_if.sv
// Bundle of Rename/RRAT-facing signals for the physical register free list.
// Handshake: a tag is transferred on a cycle where alloc_req && alloc_valid && !flush; alloc_tag is meaningful only while alloc_valid.
interface phys_reg_free_list_if #(
    parameter int TAG_W = 6
);
    logic             flush;
    logic             alloc_req;
    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic             commit_valid;
    logic             free_valid;
    logic [TAG_W-1:0] free_tag;
    logic [TAG_W:0]   free_count;
    logic             rename_halt;
    logic             overflow_err;

    modport master (
        output flush, alloc_req, commit_valid, free_valid, free_tag,
        input  alloc_valid, alloc_tag, free_count, rename_halt, overflow_err
    );

    modport slave (
        input  flush, alloc_req, commit_valid, free_valid, free_tag,
        output alloc_valid, alloc_tag, free_count, rename_halt, overflow_err
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical tags with speculative head and commit-head rollback on flush.
// Optional feature: define FREELIST_BYPASS_EN to forward a freed tag straight to Rename when the list is empty.
module phys_reg_free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = $clog2(NUM_PHYS)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    phys_reg_free_list_if.slave    fl
);
    localparam int PTR_W = TAG_W + 1;

    logic [TAG_W-1:0] mem [NUM_PHYS];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] commit_head;
    logic [PTR_W-1:0] commit_head_nxt;
    logic [PTR_W-1:0] count;
    logic             overflow_q;
    logic             full;
    logic             empty;
    logic             free_legal;
    logic             bypass;
    logic             grant;
    logic             push;
    logic             commit_ok;

    assign count      = tail - head;
    assign full       = (count == PTR_W'(NUM_PHYS));
    assign empty      = (count == '0);
    // Tag 0 holds the permanent r0 mapping and must never enter the list.
    assign free_legal = fl.free_valid && (fl.free_tag != '0);

`ifdef FREELIST_BYPASS_EN
    assign bypass = empty && free_legal;
`else
    assign bypass = 1'b0;
`endif

    assign fl.alloc_valid  = !empty || bypass;
    assign fl.alloc_tag    = bypass ? fl.free_tag : mem[head[TAG_W-1:0]];
    assign fl.free_count   = count;
    assign fl.rename_halt  = !fl.alloc_valid;
    assign fl.overflow_err = overflow_q;

    assign grant = fl.alloc_req && fl.alloc_valid && !fl.flush;
    // A forwarded tag that is granted never touches storage.
    assign push  = free_legal && !full && !(grant && bypass);

    assign commit_ok       = fl.commit_valid && (commit_head != head);
    assign commit_head_nxt = commit_head + PTR_W'(commit_ok);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                mem[i] <= (i < NUM_PHYS - NUM_ARCH) ? TAG_W'(NUM_ARCH + i) : '0;
            end
            head        <= '0;
            commit_head <= '0;
            tail        <= PTR_W'(NUM_PHYS - NUM_ARCH);
            overflow_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[tail[TAG_W-1:0]] <= fl.free_tag;
                tail                 <= tail + PTR_W'(1);
            end
            if (free_legal && full) begin
                overflow_q <= 1'b1;
            end
            commit_head <= commit_head_nxt;
            // Flush rolls head back to the retirement point, including a same-cycle commit.
            if (fl.flush) begin
                head <= commit_head_nxt;
            end else if (grant && !bypass) begin
                head <= head + PTR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: queue-based reference model, directed scenarios and random traffic.
// Works with or without FREELIST_BYPASS_EN defined.
module tb_phys_reg_free_list;
    logic clk;
    logic rst_n;

    phys_reg_free_list_if #(.TAG_W(6)) bus ();

    phys_reg_free_list dut (
        .CLK   (clk),
        .RESET (rst_n),
        .fl    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: lst holds every tag from the commit point to the tail; the first
    // spec entries are handed out but not yet retired.
    logic [5:0] lst[$];
    int         spec;
    logic       ovf;

    int n_checks;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        lst.delete();
        for (int i = 0; i < 32; i++) lst.push_back(6'(32 + i));
        spec = 0;
        ovf  = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.alloc_req    = 1'b0;
        bus.flush        = 1'b0;
        bus.commit_valid = 1'b0;
        bus.free_valid   = 1'b0;
        bus.free_tag     = '0;
    endtask

    // Drives one cycle, compares all outputs with the model at the negedge,
    // then advances the model to match the coming rising edge.
    task automatic cycle(input logic req, input logic fls, input logic cv,
                         input logic fv, input logic [5:0] ft,
                         output logic g_valid, output logic [5:0] g_tag,
                         output int fc_obs);
        int   fc;
        logic byp;
        logic av;
        logic grant;
        logic full;
        logic legal;
        bus.alloc_req    = req;
        bus.flush        = fls;
        bus.commit_valid = cv;
        bus.free_valid   = fv;
        bus.free_tag     = ft;
        @(negedge clk);
        fc    = lst.size() - spec;
        legal = fv && (ft != 0);
        byp   = 1'b0;
`ifdef FREELIST_BYPASS_EN
        byp = (fc == 0) && legal;
`endif
        av = (fc != 0) || byp;
        check("alloc_valid", 32'(bus.alloc_valid), 32'(av));
        check("rename_halt", 32'(bus.rename_halt), 32'(!av));
        check("free_count", 32'(bus.free_count), 32'(fc));
        check("overflow_err", 32'(bus.overflow_err), 32'(ovf));
        if (av) check("alloc_tag", 32'(bus.alloc_tag), 32'(byp ? ft : lst[spec]));
        g_valid = bus.alloc_valid && req && !fls;
        g_tag   = bus.alloc_tag;
        fc_obs  = int'(bus.free_count);

        grant = req && av && !fls;
        full  = (fc == 64);
        if (legal && full) ovf = 1'b1;
        if (cv && spec > 0) begin
            void'(lst.pop_front());
            spec--;
        end
        if (grant && !byp) spec++;
        if (legal && !full && !(grant && byp)) lst.push_back(ft);
        if (fls) spec = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        check("rst_alloc_valid", 32'(bus.alloc_valid), 32'd1);
        check("rst_alloc_tag", 32'(bus.alloc_tag), 32'd32);
        check("rst_free_count", 32'(bus.free_count), 32'd32);
        check("rst_overflow", 32'(bus.overflow_err), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    logic       gv;
    logic [5:0] gt;
    int         fco;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Three grants from reset, then drain to empty.
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 0, gv, gt, fco);
            check("t1_grant", 32'(gv), 32'd1);
            check("t1_tag", 32'(gt), 32'(32 + i));
        end
        for (int i = 0; i < 29; i++) cycle(1, 0, 0, 0, 0, gv, gt, fco);
        cycle(1, 0, 0, 0, 0, gv, gt, fco);
        check("t2_empty_count", 32'(fco), 32'd0);
        check("t2_empty_grant", 32'(gv), 32'd0);
        cycle(1, 0, 0, 1, 6'd5, gv, gt, fco);
`ifdef FREELIST_BYPASS_EN
        check("t2_bypass_grant", 32'(gv), 32'd1);
        check("t2_bypass_tag", 32'(gt), 32'd5);
`else
        check("t2_no_bypass", 32'(gv), 32'd0);
        cycle(1, 0, 0, 0, 0, gv, gt, fco);
        check("t2_late_grant", 32'(gv), 32'd1);
        check("t2_late_tag", 32'(gt), 32'd5);
`endif

        // Alloc 3, commit 1, flush: restart at 33.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, gv, gt, fco);
        cycle(0, 0, 1, 0, 0, gv, gt, fco);
        cycle(0, 1, 0, 0, 0, gv, gt, fco);
        cycle(1, 0, 0, 0, 0, gv, gt, fco);
        check("t3_tag", 32'(gt), 32'd33);
        check("t3_count", 32'(fco), 32'd31);

        // Commit + flush + free in one cycle after two grants.
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1, 0, 0, 0, 0, gv, gt, fco);
        cycle(0, 1, 1, 1, 6'd7, gv, gt, fco);
        for (int i = 0; i < 32; i++) begin
            cycle(1, 0, 0, 0, 0, gv, gt, fco);
            if (i == 0) begin
                check("t4_count", 32'(fco), 32'd32);
                check("t4_first", 32'(gt), 32'd33);
            end
            if (i == 30) check("t4_63", 32'(gt), 32'd63);
            if (i == 31) check("t4_7", 32'(gt), 32'd7);
        end

        // Tag 0 is ignored; 33 frees overflow the list.
        do_reset();
        cycle(0, 0, 0, 1, 6'd0, gv, gt, fco);
        cycle(0, 0, 0, 0, 0, gv, gt, fco);
        check("t5_tag0_count", 32'(fco), 32'd32);
        for (int i = 0; i < 33; i++) cycle(0, 0, 0, 1, 6'(1 + i), gv, gt, fco);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, gv, gt, fco);
        check("t5_full_count", 32'(fco), 32'd64);
        check("t5_overflow", 32'(bus.overflow_err), 32'd1);

        // Reset in the middle of an allocation burst.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0, gv, gt, fco);
        do_reset();
        cycle(1, 0, 0, 0, 0, gv, gt, fco);
        check("t6_tag", 32'(gt), 32'd32);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic       r_req, r_fl, r_cv, r_fv;
            logic [5:0] r_tag;
            r_req = ($urandom_range(0, 9) < 7);
            r_fl  = ($urandom_range(0, 99) < 4);
            r_cv  = ($urandom_range(0, 9) < 4);
            r_fv  = ($urandom_range(0, 9) < 4);
            r_tag = ($urandom_range(0, 19) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            // Never return more tags than could physically exist.
            if (!(lst.size() < 64 || spec == 0)) r_fv = 1'b0;
            cycle(r_req, r_fl, r_cv, r_fv, r_tag, gv, gt, fco);
        end

        idle_inputs();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
